// File: rtl/icache_pkg.sv
// Shared types and helpers for the set-associative icache storage.
// Tree-PLRU helpers operate on a 3-bit vector so one encoding covers 2 and 4 ways.
package icache_pkg;

  typedef enum logic [1:0] {IDLE, REFILL, FLUSH} state_t;

  function automatic int way_w(input int ways);
    return (ways > 1) ? $clog2(ways) : 1;
  endfunction

  // bit0 = root (0: left pair, 1: right pair), bit1 = left leaf, bit2 = right leaf
  function automatic logic [1:0] plru_victim(input int ways, input logic [2:0] bits);
    if (ways == 4) return bits[0] ? {1'b1, bits[2]} : {1'b0, bits[1]};
    if (ways == 2) return {1'b0, bits[0]};
    return 2'd0;
  endfunction

  function automatic logic [2:0] plru_update(input int ways, input logic [2:0] bits,
                                             input logic [1:0] way);
    logic [2:0] nb;
    nb = bits;
    if (ways == 4) begin
      nb[0] = ~way[1];
      if (way[1]) nb[2] = ~way[0];
      else        nb[1] = ~way[0];
    end else if (ways == 2) begin
      nb[0] = ~way[0];
    end
    return nb;
  endfunction

endpackage

// File: rtl/icache_plru.sv
// Per-set tree-PLRU state: victim read port, touch/update port, per-set clear for flush.
module icache_plru
  import icache_pkg::*;
#(
  parameter int WAYS = 2,
  parameter int SETS = 64,
  localparam int IDX_W = $clog2(SETS),
  localparam int WAY_W = way_w(WAYS)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [IDX_W-1:0] victim_index,
  output logic [WAY_W-1:0] victim,
  input  logic             upd_en,
  input  logic [IDX_W-1:0] upd_index,
  input  logic [WAY_W-1:0] upd_way,
  input  logic             clr_en,
  input  logic [IDX_W-1:0] clr_index
);

  generate
    if (WAYS > 1) begin : g_plru
      localparam int PB = WAYS - 1;
      logic [PB-1:0] bits [SETS];

      // clear and update never coincide: flush and refill/lookup are exclusive states
      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          for (int i = 0; i < SETS; i++) bits[i] <= '0;
        end else if (clr_en) begin
          bits[clr_index] <= '0;
        end else if (upd_en) begin
          bits[upd_index] <= PB'(plru_update(WAYS, 3'(bits[upd_index]), 2'(upd_way)));
        end
      end

      assign victim = WAY_W'(plru_victim(WAYS, 3'(bits[victim_index])));
    end else begin : g_none
      assign victim = '0;
    end
  endgenerate

endmodule

// File: rtl/icache_assoc_sram.sv
// N-way set-associative icache storage: registered lookup, word-serial refill
// with self-chosen victim, and a one-set-per-cycle flush sweep.
`ifndef DRAM_WORD_SIZE
`define DRAM_WORD_SIZE 32
`endif
`ifndef DRAM_BLOCK_SIZE
`define DRAM_BLOCK_SIZE 4
`endif

module icache_assoc_sram
  import icache_pkg::*;
#(
  parameter int WAYS        = 2,
  parameter int SETS        = 64,
  parameter int WORD_W      = `DRAM_WORD_SIZE,
  parameter int BLOCK_WORDS = `DRAM_BLOCK_SIZE,
  parameter int TAG_W       = 20,
  localparam int IDX_W = $clog2(SETS),
  localparam int WAY_W = way_w(WAYS),
  localparam int CNT_W = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              lookup_en,
  input  logic [IDX_W-1:0]  lookup_index,
  input  logic [TAG_W-1:0]  lookup_tag,
  output logic              hit_valid,
  output logic              hit,
  output logic [WAY_W-1:0]  hit_way,
  output logic [WORD_W-1:0] read_block [BLOCK_WORDS],
  input  logic              refill_start,
  input  logic [IDX_W-1:0]  refill_index,
  input  logic [TAG_W-1:0]  refill_tag,
  input  logic              refill_word_valid,
  input  logic [WORD_W-1:0] refill_word,
  output logic [WAY_W-1:0]  refill_way,
  output logic              refill_done,
  input  logic              flush_req,
  output logic              busy
);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [IDX_W-1:0]  sweep, ref_idx;
  logic [TAG_W-1:0]  ref_tag;
  logic [WORD_W-1:0] data [SETS][WAYS][BLOCK_WORDS];
  logic [TAG_W-1:0]  tags [SETS][WAYS];
  logic [WAYS-1:0]   valid [SETS];

  logic             lk_hit, beat, last_beat, do_lookup;
  logic [WAY_W-1:0] lk_way, plru_way, new_way;

  // descending scans so the lowest matching / lowest invalid way wins
  always_comb begin
    lk_hit  = 1'b0;
    lk_way  = '0;
    new_way = plru_way;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid[lookup_index][w] && tags[lookup_index][w] == lookup_tag) begin
        lk_hit = 1'b1;
        lk_way = WAY_W'(w);
      end
      if (!valid[refill_index][w]) new_way = WAY_W'(w);
    end
  end

  assign do_lookup = (state == IDLE) && !flush_req && !refill_start && lookup_en;
  assign beat      = (state == REFILL) && refill_word_valid;
  assign last_beat = beat && (cnt == CNT_W'(BLOCK_WORDS - 1));

  icache_plru #(.WAYS(WAYS), .SETS(SETS)) u_plru (
    .clock        (clock),
    .reset        (reset),
    .victim_index (refill_index),
    .victim       (plru_way),
    .upd_en       ((do_lookup && lk_hit) || last_beat),
    .upd_index    (last_beat ? ref_idx : lookup_index),
    .upd_way      (last_beat ? refill_way : lk_way),
    .clr_en       (state == FLUSH),
    .clr_index    (sweep)
  );

  always_ff @(posedge clock) begin
    if (beat)      data[ref_idx][refill_way][cnt] <= refill_word;
    if (last_beat) tags[ref_idx][refill_way]      <= ref_tag;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      sweep       <= '0;
      ref_idx     <= '0;
      ref_tag     <= '0;
      for (int i = 0; i < SETS; i++) valid[i] <= '0;
      hit_valid   <= 1'b0;
      hit         <= 1'b0;
      hit_way     <= '0;
      for (int b = 0; b < BLOCK_WORDS; b++) read_block[b] <= '0;
      refill_way  <= '0;
      refill_done <= 1'b0;
      busy        <= 1'b0;
    end else begin
      hit_valid   <= 1'b0;
      refill_done <= 1'b0;
      case (state)
        IDLE: begin
          if (flush_req) begin
            state <= FLUSH;
            sweep <= '0;
            busy  <= 1'b1;
          end else if (refill_start) begin
            state      <= REFILL;
            cnt        <= '0;
            ref_idx    <= refill_index;
            ref_tag    <= refill_tag;
            refill_way <= new_way;
            valid[refill_index][new_way] <= 1'b0;
            busy       <= 1'b1;
          end else if (lookup_en) begin
            hit_valid <= 1'b1;
            hit       <= lk_hit;
            hit_way   <= lk_way;
            for (int b = 0; b < BLOCK_WORDS; b++)
              read_block[b] <= lk_hit ? data[lookup_index][lk_way][b] : '0;
          end
        end
        REFILL: begin
          if (refill_word_valid) begin
            cnt <= cnt + 1'b1;
            if (last_beat) begin
              valid[ref_idx][refill_way] <= 1'b1;
              state       <= IDLE;
              busy        <= 1'b0;
              refill_done <= 1'b1;
            end
          end
        end
        FLUSH: begin
          valid[sweep] <= '0;
          if (sweep == IDX_W'(SETS - 1)) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            sweep <= sweep + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_icache_assoc_sram.sv
// Directed bench for icache_assoc_sram (2 ways, 64 sets, 4x32-bit lines).
module tb_icache_assoc_sram;

  localparam int SETS = 64;
  localparam int BW   = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        lookup_en = 1'b0;
  logic [5:0]  lookup_index = '0;
  logic [19:0] lookup_tag = '0;
  logic        hit_valid, hit;
  logic [0:0]  hit_way;
  logic [31:0] read_block [BW];
  logic        refill_start = 1'b0;
  logic [5:0]  refill_index = '0;
  logic [19:0] refill_tag = '0;
  logic        refill_word_valid = 1'b0;
  logic [31:0] refill_word = '0;
  logic [0:0]  refill_way;
  logic        refill_done;
  logic        flush_req = 1'b0;
  logic        busy;

  icache_assoc_sram #(.WAYS(2), .SETS(SETS), .WORD_W(32), .BLOCK_WORDS(BW), .TAG_W(20)) dut (
    .clock(clock), .reset(reset),
    .lookup_en(lookup_en), .lookup_index(lookup_index), .lookup_tag(lookup_tag),
    .hit_valid(hit_valid), .hit(hit), .hit_way(hit_way), .read_block(read_block),
    .refill_start(refill_start), .refill_index(refill_index), .refill_tag(refill_tag),
    .refill_word_valid(refill_word_valid), .refill_word(refill_word),
    .refill_way(refill_way), .refill_done(refill_done),
    .flush_req(flush_req), .busy(busy)
  );

  always #5 clock = ~clock;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    logic [5:0]   idx;
    logic [19:0]  tag;
    logic         hit;
    logic         way;
    logic [127:0] blk;
  } vec_t;

  localparam logic [19:0] TA = 20'hABCDE, TB = 20'h0B0B0, TC = 20'h0C0C0, TD = 20'hFFFFF;
  localparam logic [127:0] WA = {32'h44, 32'h33, 32'h22, 32'h11};
  localparam logic [127:0] WB = {32'hB4, 32'hB3, 32'hB2, 32'hB1};
  localparam logic [127:0] WC = {32'hC0DE_0004, 32'hC0DE_0003, 32'hC0DE_0002, 32'hC0DE_0001};
  localparam logic [127:0] WD = {32'hDEAD_BEEF, 32'h0, 32'hFFFF_FFFF, 32'h1234_5678};

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [127:0] blk();
    return {read_block[3], read_block[2], read_block[1], read_block[0]};
  endfunction

  // inputs change 1ns after a rising edge; outputs sampled 1ns after the next one
  task automatic look(input string nm, input logic [5:0] idx, input logic [19:0] tg,
                      input logic eh, input logic ew, input logic [127:0] eb);
    lookup_en = 1'b1; lookup_index = idx; lookup_tag = tg;
    @(posedge clock); #1;
    lookup_en = 1'b0;
    chk({nm, ".hit_valid"}, 128'(hit_valid), 128'(1'b1));
    chk({nm, ".hit"}, 128'(hit), 128'(eh));
    chk({nm, ".hit_way"}, 128'(hit_way), 128'(ew));
    chk({nm, ".block"}, blk(), eb);
  endtask

  task automatic refill(input string nm, input logic [5:0] idx, input logic [19:0] tg,
                        input logic [127:0] w, input bit gaps, input logic ew);
    refill_start = 1'b1; refill_index = idx; refill_tag = tg;
    @(posedge clock); #1;
    refill_start = 1'b0;
    chk({nm, ".busy"}, 128'(busy), 128'(1'b1));
    chk({nm, ".way"}, 128'(refill_way), 128'(ew));
    for (int b = 0; b < BW; b++) begin
      refill_word_valid = 1'b1;
      refill_word = w[b*32 +: 32];
      @(posedge clock); #1;
      refill_word_valid = 1'b0;
      if (b < BW - 1) begin
        chk({nm, ".early_done"}, 128'(refill_done), 128'(1'b0));
        if (gaps) begin
          @(posedge clock); #1;
          chk({nm, ".gap_busy"}, 128'(busy), 128'(1'b1));
        end
      end
    end
    chk({nm, ".done"}, 128'(refill_done), 128'(1'b1));
    chk({nm, ".busy_end"}, 128'(busy), 128'(1'b0));
  endtask

  vec_t vecs [6];

  initial begin
    int n, bad_hv, bad_done;

    vecs[0] = '{idx: 6'd5,  tag: TA,        hit: 1'b1, way: 1'b0, blk: WA};
    vecs[1] = '{idx: 6'd5,  tag: TB,        hit: 1'b0, way: 1'b0, blk: '0};
    vecs[2] = '{idx: 6'd5,  tag: TC,        hit: 1'b1, way: 1'b1, blk: WC};
    vecs[3] = '{idx: 6'd63, tag: TD,        hit: 1'b1, way: 1'b0, blk: WD};
    vecs[4] = '{idx: 6'd6,  tag: TA,        hit: 1'b0, way: 1'b0, blk: '0};
    vecs[5] = '{idx: 6'd5,  tag: 20'h12345, hit: 1'b0, way: 1'b0, blk: '0};

    repeat (2) @(posedge clock);
    #1;
    chk("rst.busy", 128'(busy), 128'(1'b0));
    chk("rst.hit_valid", 128'(hit_valid), 128'(1'b0));
    chk("rst.refill_done", 128'(refill_done), 128'(1'b0));
    chk("rst.refill_way", 128'(refill_way), 128'(1'b0));
    reset = 1'b0;
    @(posedge clock); #1;

    look("rst_lookup", 6'd5, 20'h12345, 1'b0, 1'b0, '0);
    @(posedge clock); #1;
    chk("hit_valid_pulse", 128'(hit_valid), 128'(1'b0));

    // first line lands in way 0; lookup issued the cycle refill_done is high
    refill("fillA", 6'd5, TA, WA, 1'b0, 1'b0);
    look("hitA0", 6'd5, TA, 1'b1, 1'b0, WA);
    chk("fillA.done_pulse", 128'(refill_done), 128'(1'b0));

    // way 1 still invalid; then touch A so PLRU evicts B for C (gapped beats)
    refill("fillB", 6'd5, TB, WB, 1'b0, 1'b1);
    look("hitB", 6'd5, TB, 1'b1, 1'b1, WB);
    look("hitA1", 6'd5, TA, 1'b1, 1'b0, WA);
    refill("fillC", 6'd5, TC, WC, 1'b1, 1'b1);
    refill("fill63", 6'd63, TD, WD, 1'b0, 1'b0);

    for (int i = 0; i < 6; i++)
      look($sformatf("vec%0d", i), vecs[i].idx, vecs[i].tag, vecs[i].hit, vecs[i].way, vecs[i].blk);

    // flush beats refill in the same cycle; lookups during busy are ignored
    flush_req = 1'b1; refill_start = 1'b1; refill_index = 6'd5; refill_tag = 20'h55555;
    @(posedge clock); #1;
    flush_req = 1'b0; refill_start = 1'b0;
    lookup_en = 1'b1; lookup_index = 6'd5; lookup_tag = TA;
    n = 0; bad_hv = 0; bad_done = 0;
    while (busy && n < 200) begin
      n++;
      if (hit_valid) bad_hv++;
      if (refill_done) bad_done++;
      @(posedge clock); #1;
    end
    lookup_en = 1'b0;
    chk("flush.busy_cycles", 128'(n), 128'(SETS));
    chk("flush.hit_valid_while_busy", 128'(bad_hv), 128'(0));
    chk("flush.refill_done_seen", 128'(bad_done), 128'(0));

    for (int i = 0; i < 4; i++)
      look($sformatf("postflush%0d", i), vecs[i].idx, vecs[i].tag, 1'b0, 1'b0, '0);

    // reset lands after two of four beats
    refill_start = 1'b1; refill_index = 6'd7; refill_tag = 20'h77777;
    @(posedge clock); #1;
    refill_start = 1'b0;
    for (int b = 0; b < 2; b++) begin
      refill_word_valid = 1'b1; refill_word = 32'h7000 + b;
      @(posedge clock); #1;
    end
    refill_word_valid = 1'b0;
    chk("midrst.busy_before", 128'(busy), 128'(1'b1));
    reset = 1'b1;
    #1;
    chk("midrst.busy", 128'(busy), 128'(1'b0));
    chk("midrst.refill_done", 128'(refill_done), 128'(1'b0));
    chk("midrst.refill_way", 128'(refill_way), 128'(1'b0));
    #2 reset = 1'b0;
    @(posedge clock); #1;
    look("midrst.lookup7", 6'd7, 20'h77777, 1'b0, 1'b0, '0);
    refill("refill7", 6'd7, 20'h77777, WB, 1'b0, 1'b0);
    look("hit7", 6'd7, 20'h77777, 1'b1, 1'b0, WB);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/icache_assoc_sram.md
# icache_assoc_sram

Parametrised N-way set-associative instruction-cache storage: data, tag, valid and pseudo-LRU state, with a registered lookup port, a word-serial refill engine and a sweep-based flush. It replaces the direct-mapped whole-block SRAM in the fetch stage. The icache controller issues lookups, and on a miss drives a refill from DRAM one word per accepted beat. The block picks the victim way itself and reports it.

## Interface
- WAYS, 2, associativity; legal values are 1, 2 and 4 (tree PLRU).
- SETS, 64, number of sets; must be a power of 2. IDX_W = $clog2(SETS).
- WORD_W, `DRAM_WORD_SIZE (32), instruction word width.
- BLOCK_WORDS, `DRAM_BLOCK_SIZE (4), words per line; must be a power of 2.
- TAG_W, 20, tag width.
- clock  in  1  sole clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high.
- lookup_en  in  1  lookup request; accepted only when busy=0.
- lookup_index  in  IDX_W  set index of the lookup.
- lookup_tag  in  TAG_W  tag to compare.
- hit_valid  out  1  lookup result valid; registered, single-cycle pulse.
- hit  out  1  tag match on a valid way.
- hit_way  out  max(1,$clog2(WAYS))  matching way; 0 when hit=0.
- read_block  out  WORD_W x BLOCK_WORDS (unpacked)  line data of hit_way; all zero when hit=0.
- refill_start  in  1  begin a line refill; accepted only when busy=0.
- refill_index  in  IDX_W  set to refill; sampled at start.
- refill_tag  in  TAG_W  tag to install; sampled at start.
- refill_word_valid  in  1  refill data beat.
- refill_word  in  WORD_W  refill data, in ascending word-offset order.
- refill_way  out  max(1,$clog2(WAYS))  victim way chosen; held from the cycle after start until done.
- refill_done  out  1  single-cycle pulse; line installed.
- flush_req  in  1  invalidate the whole cache.
- busy  out  1  high in REFILL and FLUSH.

## Operation
- **FSM states.** IDLE, REFILL, FLUSH.
- **IDLE priority.** flush_req first, then refill_start, then lookup_en. Lower-priority requests in the same cycle are dropped, and the caller re-issues them.
- **Lookup.**
  - Compare lookup_tag against all valid ways of the set.
  - On a hit, register the hit data and point that set's PLRU away from hit_way.
  - On a miss, leave the PLRU unchanged.
  - If more than one way matches, which can only happen from a controller error, the lowest matching way wins.
- **Refill start.**
  - Victim is the lowest-numbered invalid way, otherwise the PLRU way.
  - The victim's valid bit clears at once.
  - The beat counter is set to 0 and the FSM enters REFILL.
- **REFILL.**
  - Each refill_word_valid beat writes data[set][victim][count], then increments count.
  - On the beat where count = BLOCK_WORDS-1, the tag is written, valid is set and the PLRU points away from the victim. The FSM then returns to IDLE and pulses refill_done.
  - Beats arriving outside REFILL are ignored.
- **FLUSH.** A sweep counter clears valid and PLRU for one set per cycle, sets 0 to SETS-1, then the FSM returns to IDLE. Tag and data arrays are not cleared.
- **Requests while busy.** lookup_en, refill_start and flush_req are all ignored while busy=1, and hit_valid stays 0.
- **Reset (async).** Applies at any time, including mid-refill or mid-flush.
  - Forces IDLE and clears every valid bit, every PLRU bit and all counters.
  - Clears all outputs to 0: hit_valid, hit, hit_way, read_block, refill_way, refill_done, busy.
  - Tag and data arrays are not reset.
- **WAYS=1.** The PLRU is absent; the victim is always way 0.

## Timing
- **Lookup.** Accepted at edge N; results are valid in the cycle after N, and hit_valid is a one-cycle pulse.
- **Refill start.** refill_start accepted at edge S; busy=1 and refill_way are valid from S+1.
- **Refill completion.**
  - The last beat is at edge L. refill_done=1 and busy=0 in cycle L+1.
  - A lookup issued in cycle L+1 sees the new line.
  - Minimum refill: BLOCK_WORDS cycles of busy with back-to-back beats.
- **Flush.** flush_req accepted at F.
  - busy=1 for exactly SETS cycles, with set i cleared at edge F+1+i.
  - Lookups may be accepted from cycle F+SETS+1.
- **Refill bubbles.** Gaps in refill_word_valid extend REFILL with no timeout.

## Structure
- **Package icache_pkg.** Holds the state enum (IDLE/REFILL/FLUSH), the PLRU update function, the PLRU victim function and the way-index width function.
- **Sub-module icache_plru.** Per-set tree-PLRU bit storage with an async-reset clear, a per-set clear port for the flush sweep, and victim/update ports.
- **Arrays.** Data and tag arrays are plain unpacked arrays with no reset. Valid bits are flops with async reset.

## Test plan
- **Reset state.** Assert reset, release, lookup idx 5 tag 0x12345 → hit_valid=1, hit=0, read_block all 0.
- **Refill then hit.** Refill idx 5 tag 0xABCDE with words 0x11, 0x22, 0x33, 0x44 on back-to-back beats → refill_way=0, refill_done exactly 4 cycles after the start edge. Then lookup → hit=1, hit_way=0, read_block={0x11,0x22,0x33,0x44}.
- **Victim selection (WAYS=2).** Fill ways 0 and 1 of idx 5 with tags A and B, hit on A, refill tag C → refill_way=1, and a lookup for B misses.
- **Priority and busy.** Assert flush_req and refill_start in the same cycle → busy for exactly 64 cycles, no refill_done, all prior lines miss afterwards. A lookup_en during busy → no hit_valid.
- **Reset mid-refill.** Assert reset after 2 of 4 beats → busy=0 and refill_done=0 immediately; a lookup of that line misses.
- **Beat gaps.** refill_word_valid toggles 1,0,1,0,... → data lands in order, and refill_done comes 1 cycle after the 4th valid beat.
